// File: rtl/soric_sram_1rw1r_param_if.sv
// Port bundle for the 1RW+1R SRAM: port 0 read/write, port 1 read-only, plus init status.
interface soric_sram_1rw1r_param_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 4
);
  logic                   init_done;
  logic                   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  dout0;
  logic                   dout0_valid;
  logic                   csb1;
  logic [ADDR_WIDTH-1:0]  addr1;
  logic [DATA_WIDTH-1:0]  dout1;
  logic                   dout1_valid;

  modport master (
    input  init_done, dout0, dout0_valid, dout1, dout1_valid,
    output csb0, web0, wmask0, addr0, din0, csb1, addr1
  );

  modport slave (
    output init_done, dout0, dout0_valid, dout1, dout1_valid,
    input  csb0, web0, wmask0, addr0, din0, csb1, addr1
  );
endinterface

// File: rtl/soric_sram_1rw1r_param.sv
// Parametrised behavioural 1RW+1R SRAM with optional post-reset zero-clear, read-valid
// strobes, 1- or 2-cycle read latency and a selectable same-address write/read bypass.
module soric_sram_1rw1r_param #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int WMASK_WIDTH  = 4,
  parameter int READ_LATENCY = 1,
  parameter bit INIT_CLEAR   = 1'b1,
  parameter bit BYPASS       = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  soric_sram_1rw1r_param_if.slave  bus
);
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;

  typedef enum logic {ST_CLEAR, ST_READY} state_e;
  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 mem [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_we, ready, wr_en, rd0_en, rd1_en;
  word_t                 bit_mask, wr_word;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = !rst;
        cnt_d  = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  assign ready         = (state_q == ST_READY) && !rst;
  assign bus.init_done = (state_q == ST_READY);
  assign wr_en         = ready && !bus.csb0 && !bus.web0;
  assign rd0_en        = ready && !bus.csb0 &&  bus.web0;
  assign rd1_en        = ready && !bus.csb1;

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      bit_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{bus.wmask0[i]}};
    end
  end

  // Merged word: masked lanes from din0, the rest from the current contents.
  assign wr_word = (mem[bus.addr0] & ~bit_mask) | (bus.din0 & bit_mask);

  // NOTE: the array itself has no reset; the CLEAR walk zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      mem[bus.addr0] <= wr_word;
    end
  end

  word_t d0_q, d1_q;
  logic  v0_q, v1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d0_q <= '0;
      d1_q <= '0;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
      v0_q <= rd0_en;
      v1_q <= rd1_en;
      if (rd0_en) d0_q <= mem[bus.addr0];
      if (rd1_en) d1_q <= (BYPASS && wr_en && (bus.addr0 == bus.addr1)) ? wr_word
                                                                        : mem[bus.addr1];
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    word_t d0_o_q, d1_o_q;
    logic  v0_o_q, v1_o_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        d0_o_q <= '0;
        d1_o_q <= '0;
        v0_o_q <= 1'b0;
        v1_o_q <= 1'b0;
      end else begin
        v0_o_q <= v0_q;
        v1_o_q <= v1_q;
        if (v0_q) d0_o_q <= d0_q;
        if (v1_q) d1_o_q <= d1_q;
      end
    end

    assign bus.dout0       = d0_o_q;
    assign bus.dout0_valid = v0_o_q;
    assign bus.dout1       = d1_o_q;
    assign bus.dout1_valid = v1_o_q;
  end else begin : g_lat1
    assign bus.dout0       = d0_q;
    assign bus.dout0_valid = v0_q;
    assign bus.dout1       = d1_q;
    assign bus.dout1_valid = v1_q;
  end

  // Backdoor access for debug; not used by the datapath.
  function automatic word_t readWord(input logic [ADDR_WIDTH-1:0] addr);
    return mem[addr];
  endfunction

  task automatic writeWord(input logic [ADDR_WIDTH-1:0] addr, input word_t val);
    mem[addr] <= val;
  endtask
endmodule

// File: tb/tb_soric_sram_1rw1r_param.sv
// Bench for soric_sram_1rw1r_param: two instances (lat1/bypass, lat2/no-bypass) share stimulus
// and are checked against a reference memory model through per-port expectation queues.
module tb_soric_sram_1rw1r_param;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int MW    = 4;
  localparam int LW    = DW / MW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          csb0, web0, csb1;
  logic [MW-1:0] wmask0;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] din0;

  always #5 clk = ~clk;

  soric_sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus_a ();
  soric_sram_1rw1r_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus_b ();

  assign bus_a.csb0 = csb0;   assign bus_b.csb0 = csb0;
  assign bus_a.web0 = web0;   assign bus_b.web0 = web0;
  assign bus_a.wmask0 = wmask0; assign bus_b.wmask0 = wmask0;
  assign bus_a.addr0 = addr0; assign bus_b.addr0 = addr0;
  assign bus_a.din0 = din0;   assign bus_b.din0 = din0;
  assign bus_a.csb1 = csb1;   assign bus_b.csb1 = csb1;
  assign bus_a.addr1 = addr1; assign bus_b.addr1 = addr1;

  soric_sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .READ_LATENCY(1), .INIT_CLEAR(1'b1), .BYPASS(1'b1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  soric_sram_1rw1r_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW),
    .READ_LATENCY(2), .INIT_CLEAR(1'b1), .BYPASS(1'b0)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    logic          has_exp;
    logic [DW-1:0] exp;
  } sb_t;

  typedef struct {
    logic          csb0, web0;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic          csb1;
    logic [AW-1:0] addr1;
    logic          chk0;
    logic [DW-1:0] exp0;
    logic          chk1;
    logic [DW-1:0] exp1_byp, exp1_nobyp;
  } vec_t;

  // Ports: 0 = a.dout0, 1 = a.dout1, 2 = b.dout0, 3 = b.dout1
  sb_t           sbq [4][$];
  logic [DW-1:0] last [4];
  logic [DW-1:0] mdl [DEPTH];
  int            mdl_cnt;
  bit            mdl_ready;
  int            cyc;
  int            n_tests = 0;
  int            n_fail  = 0;

  logic          t_chk0, t_chk1;
  logic [DW-1:0] t_exp0, t_exp1b, t_exp1n;

  vec_t tbl [16];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat(input int p);
    return (p < 2) ? 1 : 2;
  endfunction

  function automatic logic port_valid(input int p);
    case (p)
      0:       return bus_a.dout0_valid;
      1:       return bus_a.dout1_valid;
      2:       return bus_b.dout0_valid;
      default: return bus_b.dout1_valid;
    endcase
  endfunction

  function automatic logic [DW-1:0] port_dout(input int p);
    case (p)
      0:       return bus_a.dout0;
      1:       return bus_a.dout1;
      2:       return bus_b.dout0;
      default: return bus_b.dout1;
    endcase
  endfunction

  task automatic push(input int p, input logic [DW-1:0] d, input logic he, input logic [DW-1:0] ex);
    sb_t e;
    e.data    = d;
    e.due     = cyc + lat(p) - 1;
    e.has_exp = he;
    e.exp     = ex;
    sbq[p].push_back(e);
  endtask

  task automatic check_port(input int p);
    sb_t   e;
    logic  exp_v;
    string nm;
    nm    = $sformatf("dut_%s_dout%0d", (p < 2) ? "a" : "b", p % 2);
    exp_v = (sbq[p].size() != 0) && (sbq[p][0].due == cyc);
    check({nm, "_valid"}, DW'(port_valid(p)), DW'(exp_v));
    if (exp_v) begin
      e = sbq[p].pop_front();
      check({nm, "_data"}, port_dout(p), e.data);
      if (e.has_exp) check({nm, "_table"}, port_dout(p), e.exp);
      last[p] = e.data;
    end else begin
      check({nm, "_hold"}, port_dout(p), last[p]);
    end
  endtask

  // One clock edge: advance the model for what the DUTs sample, then check outputs #1 later.
  task automatic tick();
    logic [DW-1:0] bm, old0, old1, mrg;
    bit            wr, coll;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        sbq[p].delete();
        last[p] = '0;
      end
      mdl_cnt   = 0;
      mdl_ready = 1'b0;
    end else if (!mdl_ready) begin
      mdl[mdl_cnt] = '0;
      mdl_cnt++;
      if (mdl_cnt == DEPTH) mdl_ready = 1'b1;
    end else begin
      bm = '0;
      for (int i = 0; i < MW; i++) bm[i*LW +: LW] = {LW{wmask0[i]}};
      old0 = mdl[addr0];
      old1 = mdl[addr1];
      mrg  = (old0 & ~bm) | (din0 & bm);
      wr   = !csb0 && !web0;
      coll = wr && (addr0 == addr1);
      if (!csb0 && web0) begin
        push(0, old0, t_chk0, t_exp0);
        push(2, old0, t_chk0, t_exp0);
      end
      if (!csb1) begin
        push(1, coll ? mrg : old1, t_chk1, t_exp1b);
        push(3, old1, t_chk1, t_exp1n);
      end
      if (wr) mdl[addr0] = mrg;
    end
    #1;
    for (int p = 0; p < 4; p++) check_port(p);
    check("init_done_a", DW'(bus_a.init_done), DW'(mdl_ready));
    check("init_done_b", DW'(bus_b.init_done), DW'(mdl_ready));
  endtask

  task automatic drive_idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = '0; addr0 = '0; din0 = '0;
    csb1 = 1'b1; addr1 = '0;
    t_chk0 = 1'b0; t_chk1 = 1'b0; t_exp0 = '0; t_exp1b = '0; t_exp1n = '0;
  endtask

  // Counts edges from rst falling until init_done rises; must be exactly DEPTH.
  task automatic wait_init(input int start, input string nm);
    int n;
    n = start;
    while (!bus_a.init_done && n < DEPTH + 50) begin
      tick();
      n++;
    end
    check(nm, DW'(n), DW'(DEPTH));
  endtask

  function automatic vec_t mkv(
    input logic c0, input logic w0, input logic [MW-1:0] m, input logic [AW-1:0] a0,
    input logic [DW-1:0] d, input logic c1, input logic [AW-1:0] a1,
    input logic k0, input logic [DW-1:0] e0, input logic k1,
    input logic [DW-1:0] e1b, input logic [DW-1:0] e1n);
    vec_t v;
    v.csb0 = c0; v.web0 = w0; v.wmask0 = m; v.addr0 = a0; v.din0 = d;
    v.csb1 = c1; v.addr1 = a1; v.chk0 = k0; v.exp0 = e0;
    v.chk1 = k1; v.exp1_byp = e1b; v.exp1_nobyp = e1n;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            c0 w0 mask   a0     din           c1 a1     k0 exp0          k1 exp1_byp      exp1_nobyp
    tbl[0]  = mkv(0, 1, 4'h0, 8'h00, 32'h0,        0, 8'hFF, 1, 32'h0,        1, 32'h0,        32'h0);
    tbl[1]  = mkv(0, 0, 4'hF, 8'h10, 32'hDEADBEEF, 1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
    tbl[2]  = mkv(0, 0, 4'h5, 8'h10, 32'h11223344, 1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
    tbl[3]  = mkv(0, 1, 4'h0, 8'h10, 32'h0,        0, 8'h10, 1, 32'hDE22BE44, 1, 32'hDE22BE44, 32'hDE22BE44);
    tbl[4]  = mkv(0, 0, 4'hF, 8'h20, 32'hA5A5A5A5, 0, 8'h20, 0, 32'h0,        1, 32'hA5A5A5A5, 32'h0);
    tbl[5]  = mkv(0, 1, 4'h0, 8'h20, 32'h0,        0, 8'h20, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 32'hA5A5A5A5);
    tbl[6]  = mkv(0, 0, 4'h0, 8'h10, 32'hFFFFFFFF, 0, 8'h10, 0, 32'h0,        1, 32'hDE22BE44, 32'hDE22BE44);
    tbl[7]  = mkv(0, 1, 4'h0, 8'h10, 32'h0,        1, 8'h00, 1, 32'hDE22BE44, 0, 32'h0,        32'h0);
    tbl[8]  = mkv(0, 0, 4'h8, 8'hFF, 32'h77000000, 0, 8'hFF, 0, 32'h0,        1, 32'h77000000, 32'h0);
    tbl[9]  = mkv(0, 1, 4'h0, 8'hFF, 32'h0,        1, 8'h00, 1, 32'h77000000, 0, 32'h0,        32'h0);
    tbl[10] = mkv(0, 0, 4'hF, 8'h01, 32'h101,      1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
    tbl[11] = mkv(0, 0, 4'hF, 8'h02, 32'h202,      1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
    tbl[12] = mkv(0, 0, 4'hF, 8'h03, 32'h303,      1, 8'h00, 0, 32'h0,        0, 32'h0,        32'h0);
    tbl[13] = mkv(0, 1, 4'h0, 8'h01, 32'h0,        0, 8'h03, 1, 32'h101,      1, 32'h303,      32'h303);
    tbl[14] = mkv(0, 1, 4'h0, 8'h02, 32'h0,        0, 8'h02, 1, 32'h202,      1, 32'h202,      32'h202);
    tbl[15] = mkv(0, 1, 4'h0, 8'h03, 32'h0,        0, 8'h01, 1, 32'h303,      1, 32'h101,      32'h101);

    cyc = 0;
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;

    // Requests during CLEAR, including a write to an already-cleared word, must be dropped.
    for (int i = 0; i < 4; i++) begin
      csb0 = 1'b0; web0 = (i != 2); wmask0 = '1; addr0 = '0; din0 = '1;
      csb1 = 1'b0; addr1 = 8'h05;
      tick();
    end
    drive_idle();
    wait_init(4, "init_latency");

    for (int i = 0; i < 16; i++) begin
      csb0 = tbl[i].csb0; web0 = tbl[i].web0; wmask0 = tbl[i].wmask0;
      addr0 = tbl[i].addr0; din0 = tbl[i].din0; csb1 = tbl[i].csb1; addr1 = tbl[i].addr1;
      t_chk0 = tbl[i].chk0; t_exp0 = tbl[i].exp0;
      t_chk1 = tbl[i].chk1; t_exp1b = tbl[i].exp1_byp; t_exp1n = tbl[i].exp1_nobyp;
      tick();
    end
    drive_idle();
    for (int i = 0; i < 3; i++) tick();

    // Random traffic on a small address window to provoke collisions and masked merges.
    for (int i = 0; i < 300; i++) begin
      csb0   = 1'($urandom_range(0, 3) == 0);
      web0   = 1'($urandom_range(0, 1));
      wmask0 = MW'($urandom_range(0, 15));
      addr0  = AW'($urandom_range(0, 7));
      din0   = $urandom;
      csb1   = 1'($urandom_range(0, 3) == 0);
      addr1  = AW'($urandom_range(0, 7));
      tick();
    end
    drive_idle();
    for (int i = 0; i < 3; i++) tick();

    // Reset one cycle after a read: the latency-2 result must never appear, outputs go to zero.
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
    tick();
    drive_idle();
    rst = 1'b1;
    tick();
    check("rst_flush_b_valid0", DW'(bus_b.dout0_valid), '0);
    check("rst_flush_b_valid1", DW'(bus_b.dout1_valid), '0);
    check("rst_flush_a_dout0", bus_a.dout0, '0);
    check("rst_flush_b_dout1", bus_b.dout1, '0);
    rst = 1'b0;
    wait_init(0, "reinit_latency");

    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10; csb1 = 1'b0; addr1 = 8'h10;
    t_chk0 = 1'b1; t_exp0 = '0; t_chk1 = 1'b1; t_exp1b = '0; t_exp1n = '0;
    tick();
    drive_idle();
    for (int i = 0; i < 3; i++) tick();

    for (int p = 0; p < 4; p++) check($sformatf("queue_drained_%0d", p), DW'(sbq[p].size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
